// File: rtl/i2c_pkg.sv
// Shared I2C definitions: sequencer FSM states, default-width command record
// and small sizing helpers used by the command path.
package i2c_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        RESPOND
    } i2c_seq_state_e;

    // Default operand widths for a 7-bit addressed device with 8-bit registers
    localparam int unsigned I2C_DEF_DATA_W = 8;
    localparam int unsigned I2C_DEF_REG_W  = 8;
    localparam int unsigned I2C_DEF_ADDR_W = 7;

    // One queued command at default widths
    typedef struct packed {
        logic                      rw;
        logic [I2C_DEF_ADDR_W-1:0] dev;
        logic [I2C_DEF_REG_W-1:0]  regaddr;
        logic [I2C_DEF_DATA_W-1:0] data;
    } i2c_cmd_t;

    // Width of an occupancy counter able to hold 0..depth inclusive
    function automatic int unsigned i2c_level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Command FIFO: power-of-two ring buffer of command records with an
// occupancy counter. Head is presented combinationally; push when full and
// pop when empty are ignored.
module i2c_cmd_fifo
    import i2c_pkg::*;
#(
    parameter type         T     = i2c_cmd_t,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = i2c_level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    output T              head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [LW-1:0] level_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("i2c_cmd_fifo: DEPTH must be a power of two and at least 2");
    end

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents need no reset since the level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps the level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// I2C command sequencer: queues register read/write commands and feeds them
// one at a time to a byte-level I2C master, using the master's busy
// rise/fall as the start/finish handshake, with a bounded wait on each edge.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned REGISTER_ADDR_WIDTH = 8,
    parameter int unsigned ADDRESS_WIDTH       = 7,
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES      = 65535,
    localparam int unsigned LVL_W              = i2c_level_width(FIFO_DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_rw,
    input  logic [ADDRESS_WIDTH-1:0]       cmd_dev,
    input  logic [REGISTER_ADDR_WIDTH-1:0] cmd_reg,
    input  logic [DATA_WIDTH-1:0]          cmd_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_rw,
    output logic                           rsp_timeout,
    output logic                           i2c_en,
    output logic                           i2c_rw,
    output logic [ADDRESS_WIDTH-1:0]       i2c_device_addr,
    output logic [REGISTER_ADDR_WIDTH-1:0] i2c_register_addr,
    output logic [DATA_WIDTH-1:0]          i2c_mosi,
    input  logic                           i2c_busy,
    input  logic [DATA_WIDTH-1:0]          i2c_miso,
    output logic [LVL_W-1:0]               fifo_level
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Command record at this instance's operand widths
    typedef struct packed {
        logic                           rw;
        logic [ADDRESS_WIDTH-1:0]       dev;
        logic [REGISTER_ADDR_WIDTH-1:0] regaddr;
        logic [DATA_WIDTH-1:0]          data;
    } cmd_t;

    i2c_seq_state_e  state_q;
    cmd_t            op_q;
    logic            en_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic            rsp_rw_q;
    logic            rsp_timeout_q;

    cmd_t            push_cmd;
    cmd_t            fifo_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_push;
    logic            fifo_pop;
    logic            wait_expired;

    assign push_cmd  = '{rw: cmd_rw, dev: cmd_dev, regaddr: cmd_reg, data: cmd_data};
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !rsp_valid_q;

    // Counter value after TIMEOUT_CYCLES full cycles spent in a wait state
    assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    i2c_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (fifo_level)
    );

    assign i2c_en            = en_q;
    assign i2c_rw            = op_q.rw;
    assign i2c_device_addr   = op_q.dev;
    assign i2c_register_addr = op_q.regaddr;
    assign i2c_mosi          = op_q.data;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_rw            = rsp_rw_q;
    assign rsp_timeout       = rsp_timeout_q;

    // Sequencer FSM: pop, request, wait busy rise, wait busy fall, respond
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            op_q          <= '0;
            en_q          <= 1'b0;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_rw_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        op_q    <= fifo_head;
                        en_q    <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT_HI;
                end
                WAIT_HI: begin
                    // Master only samples en on its divider tick, so keep it up until busy
                    if (i2c_busy) begin
                        en_q       <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= WAIT_LO;
                    end else if (wait_expired) begin
                        en_q          <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= '0;
                        rsp_rw_q      <= op_q.rw;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESPOND;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!i2c_busy) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= op_q.rw ? i2c_miso : '0;
                        rsp_rw_q      <= op_q.rw;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESPOND;
                    end else if (wait_expired) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= '0;
                        rsp_rw_q      <= op_q.rw;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESPOND;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a simple busy-handshake master model.
module tb_i2c_cmd_sequencer;

    localparam int unsigned TO = 24;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev = '0;
    logic [7:0] cmd_reg = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_rw;
    logic       rsp_timeout;
    logic       i2c_en;
    logic       i2c_rw;
    logic [6:0] i2c_device_addr;
    logic [7:0] i2c_register_addr;
    logic [7:0] i2c_mosi;
    logic       i2c_busy;
    logic [7:0] i2c_miso;
    logic [2:0] fifo_level;

    int checks = 0;
    int passed = 0;

    bit         model_on = 1'b0;
    bit         model_echo = 1'b0;
    logic [7:0] model_miso = 8'h00;

    i2c_cmd_sequencer #(
        .DATA_WIDTH          (8),
        .REGISTER_ADDR_WIDTH (8),
        .ADDRESS_WIDTH       (7),
        .FIFO_DEPTH          (4),
        .TIMEOUT_CYCLES      (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_rw            (cmd_rw),
        .cmd_dev           (cmd_dev),
        .cmd_reg           (cmd_reg),
        .cmd_data          (cmd_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .rsp_rw            (rsp_rw),
        .rsp_timeout       (rsp_timeout),
        .i2c_en            (i2c_en),
        .i2c_rw            (i2c_rw),
        .i2c_device_addr   (i2c_device_addr),
        .i2c_register_addr (i2c_register_addr),
        .i2c_mosi          (i2c_mosi),
        .i2c_busy          (i2c_busy),
        .i2c_miso          (i2c_miso),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;

    // Master model: busy rises 3 cycles after en is seen, falls 20 cycles later
    initial begin
        i2c_busy = 1'b0;
        i2c_miso = 8'h00;
        forever begin
            @(negedge clk);
            if (model_on && i2c_en && !i2c_busy) begin
                repeat (3) @(negedge clk);
                i2c_busy = 1'b1;
                repeat (20) @(negedge clk);
                i2c_miso = model_echo ? (i2c_register_addr ^ 8'hFF) : model_miso;
                i2c_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    task automatic push(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dt);
        cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_data = dt; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Runs until a response is held; counts en-high cycles and snapshots the first operands
    task automatic run_until_rsp(output int en_cnt, output logic [23:0] ops, output bit got);
        bit seen;
        en_cnt = 0; ops = '0; got = 1'b0; seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (i2c_en) begin
                en_cnt++;
                if (!seen) begin
                    seen = 1'b1;
                    ops = {i2c_rw, i2c_device_addr, i2c_register_addr, i2c_mosi};
                end
            end
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if (i2c_en !== 1'b0) $display("FAIL reset_en: got %b want 0", i2c_en); else passed++;
        checks++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h want 00", rsp_data); else passed++;
        checks++; if ({rsp_rw, rsp_timeout} !== 2'b00) $display("FAIL reset_rsp_flags: got %b want 00", {rsp_rw, rsp_timeout}); else passed++;
        checks++; if ({i2c_rw, i2c_device_addr, i2c_register_addr, i2c_mosi} !== 24'h0)
            $display("FAIL reset_operands: got %h want 000000", {i2c_rw, i2c_device_addr, i2c_register_addr, i2c_mosi}); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int          en_cnt;
        logic [23:0] ops;
        bit          got;
        bit          extra;
        model_on = 1'b1; model_echo = 1'b0; model_miso = 8'hEE;
        push(1'b0, 7'h50, 8'h10, 8'hA5);
        run_until_rsp(en_cnt, ops, got);
        checks++; if (got !== 1'b1) $display("FAIL write_rsp_seen: got %b want 1", got); else passed++;
        checks++; if (en_cnt != 4) $display("FAIL write_en_hold: got %0d cycles want 4", en_cnt); else passed++;
        checks++; if (ops !== {1'b0, 7'h50, 8'h10, 8'hA5}) $display("FAIL write_operands: got %h want %h", ops, {1'b0, 7'h50, 8'h10, 8'hA5}); else passed++;
        checks++; if (rsp_rw !== 1'b0) $display("FAIL write_rsp_rw: got %b want 0", rsp_rw); else passed++;
        checks++; if (rsp_data !== 8'h00) $display("FAIL write_rsp_data: got %h want 00", rsp_data); else passed++;
        checks++; if (rsp_timeout !== 1'b0) $display("FAIL write_rsp_timeout: got %b want 0", rsp_timeout); else passed++;
        take_rsp();
        extra = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid || i2c_en) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) $display("FAIL write_single_rsp: got extra activity %b want 0", extra); else passed++;
    endtask

    task automatic test_read();
        int          en_cnt;
        logic [23:0] ops;
        bit          got;
        model_on = 1'b1; model_echo = 1'b0; model_miso = 8'h3C;
        push(1'b1, 7'h50, 8'h20, 8'h00);
        run_until_rsp(en_cnt, ops, got);
        checks++; if (got !== 1'b1) $display("FAIL read_rsp_seen: got %b want 1", got); else passed++;
        checks++; if (ops !== {1'b1, 7'h50, 8'h20, 8'h00}) $display("FAIL read_operands: got %h want %h", ops, {1'b1, 7'h50, 8'h20, 8'h00}); else passed++;
        checks++; if (rsp_data !== 8'h3C) $display("FAIL read_rsp_data: got %h want 3c", rsp_data); else passed++;
        checks++; if (rsp_rw !== 1'b1) $display("FAIL read_rsp_rw: got %b want 1", rsp_rw); else passed++;
        checks++; if (rsp_timeout !== 1'b0) $display("FAIL read_rsp_timeout: got %b want 0", rsp_timeout); else passed++;
        take_rsp();
    endtask

    task automatic test_back_to_back();
        int          acc;
        int          en_cnt;
        logic [23:0] ops;
        bit          got;
        logic [7:0]  exp;
        model_on = 1'b0; model_echo = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_rw = 1'b1; cmd_dev = 7'(16 + i); cmd_reg = 8'(64 + i); cmd_data = 8'(i); cmd_valid = 1'b1;
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++; if (acc != 5) $display("FAIL b2b_accepted: got %0d want 5", acc); else passed++;
        checks++; if (fifo_level !== 3'd4) $display("FAIL b2b_level_full: got %0d want 4", fifo_level); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_ready_low: got %b want 0", cmd_ready); else passed++;
        cmd_rw = 1'b1; cmd_dev = 7'h7F; cmd_reg = 8'h99; cmd_data = 8'h99; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) $display("FAIL b2b_no_push_full: got %0d want 4", fifo_level); else passed++;
        model_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_until_rsp(en_cnt, ops, got);
            exp = 8'(64 + i) ^ 8'hFF;
            checks++; if (got !== 1'b1 || rsp_data !== exp || rsp_timeout !== 1'b0)
                $display("FAIL b2b_order_%0d: got valid=%b data=%h to=%b want valid=1 data=%h to=0", i, got, rsp_data, rsp_timeout, exp); else passed++;
            take_rsp();
        end
        checks++; if (fifo_level !== 3'd0) $display("FAIL b2b_drained: got %0d want 0", fifo_level); else passed++;
        model_echo = 1'b0;
    endtask

    task automatic test_timeout();
        int          en_cnt;
        logic [23:0] ops;
        bit          got;
        model_on = 1'b0;
        push(1'b0, 7'h33, 8'h44, 8'h55);
        run_until_rsp(en_cnt, ops, got);
        checks++; if (got !== 1'b1) $display("FAIL to_rsp_seen: got %b want 1", got); else passed++;
        checks++; if (en_cnt != int'(TO + 1)) $display("FAIL to_en_cycles: got %0d want %0d", en_cnt, TO + 1); else passed++;
        checks++; if (rsp_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", rsp_timeout); else passed++;
        checks++; if (rsp_data !== 8'h00) $display("FAIL to_rsp_data: got %h want 00", rsp_data); else passed++;
        checks++; if (i2c_en !== 1'b0) $display("FAIL to_en_low: got %b want 0", i2c_en); else passed++;
        take_rsp();
        model_on = 1'b1; model_miso = 8'h5A;
        push(1'b1, 7'h21, 8'h22, 8'h00);
        run_until_rsp(en_cnt, ops, got);
        checks++; if (got !== 1'b1 || rsp_timeout !== 1'b0) $display("FAIL to_next_ok: got valid=%b to=%b want valid=1 to=0", got, rsp_timeout); else passed++;
        checks++; if (rsp_data !== 8'h5A) $display("FAIL to_next_data: got %h want 5a", rsp_data); else passed++;
        checks++; if (en_cnt != 4) $display("FAIL to_next_en_hold: got %0d want 4", en_cnt); else passed++;
        take_rsp();
    endtask

    task automatic test_stall();
        int          en_cnt;
        logic [23:0] ops;
        bit          got;
        logic [9:0]  held;
        bit          unstable;
        bit          en_seen;
        model_on = 1'b1; model_miso = 8'hC3;
        push(1'b1, 7'h11, 8'h12, 8'h00);
        push(1'b0, 7'h13, 8'h14, 8'h15);
        run_until_rsp(en_cnt, ops, got);
        checks++; if (got !== 1'b1) $display("FAIL stall_rsp_seen: got %b want 1", got); else passed++;
        checks++; if (rsp_data !== 8'hC3) $display("FAIL stall_rsp_data: got %h want c3", rsp_data); else passed++;
        held = {rsp_valid, rsp_data, rsp_timeout};
        unstable = 1'b0; en_seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_data, rsp_timeout} !== held || rsp_rw !== 1'b1) unstable = 1'b1;
            if (i2c_en) en_seen = 1'b1;
        end
        checks++; if (unstable !== 1'b0) $display("FAIL stall_fields_stable: got changed=%b want 0", unstable); else passed++;
        checks++; if (en_seen !== 1'b0) $display("FAIL stall_no_en: got en_seen=%b want 0", en_seen); else passed++;
        checks++; if (fifo_level !== 3'd1) $display("FAIL stall_queued: got %0d want 1", fifo_level); else passed++;
        take_rsp();
        run_until_rsp(en_cnt, ops, got);
        checks++; if (got !== 1'b1 || rsp_rw !== 1'b0 || rsp_data !== 8'h00)
            $display("FAIL stall_second: got valid=%b rw=%b data=%h want valid=1 rw=0 data=00", got, rsp_rw, rsp_data); else passed++;
        checks++; if (ops !== {1'b0, 7'h13, 8'h14, 8'h15}) $display("FAIL stall_second_ops: got %h want %h", ops, {1'b0, 7'h13, 8'h14, 8'h15}); else passed++;
        take_rsp();
    endtask

    task automatic test_reset_mid();
        bit reached;
        bit activity;
        model_on = 1'b1; model_miso = 8'h77;
        push(1'b1, 7'h01, 8'h01, 8'h00);
        push(1'b1, 7'h02, 8'h02, 8'h00);
        push(1'b1, 7'h03, 8'h03, 8'h00);
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (i2c_busy && !i2c_en) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (reached !== 1'b1) $display("FAIL rst_mid_wait_lo: got %b want 1", reached); else passed++;
        checks++; if (fifo_level !== 3'd2) $display("FAIL rst_mid_queued: got %0d want 2", fifo_level); else passed++;
        model_on = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (fifo_level !== 3'd0) $display("FAIL rst_mid_level: got %0d want 0", fifo_level); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", cmd_ready); else passed++;
        checks++; if (i2c_en !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL rst_mid_en_valid: got en=%b valid=%b want 0 0", i2c_en, rsp_valid); else passed++;
        checks++; if ({i2c_rw, i2c_device_addr, i2c_register_addr, i2c_mosi} !== 24'h0)
            $display("FAIL rst_mid_operands: got %h want 000000", {i2c_rw, i2c_device_addr, i2c_register_addr, i2c_mosi}); else passed++;
        checks++; if ({rsp_data, rsp_rw, rsp_timeout} !== 10'h0) $display("FAIL rst_mid_rsp: got %h want 000", {rsp_data, rsp_rw, rsp_timeout}); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        activity = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid || i2c_en) activity = 1'b1;
        end
        checks++; if (activity !== 1'b0) $display("FAIL rst_mid_no_rsp: got activity=%b want 0", activity); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
